// File: rtl/reset_sequencer.sv
// Sequences release of N_STAGES downstream reset domains once the PLL is locked,
// one stage at a time, each gated by the previous stage's ready acknowledge.
module reset_sequencer #(
    parameter int N_STAGES    = 4,
    parameter int STAGE_DELAY = 256,
    parameter int TIMEOUT     = 4096,
    parameter int RETRY_MAX   = 3,
    localparam int RC_W       = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lock_in,
    input  logic                sw_rst_req,
    input  logic [N_STAGES-1:0] stage_ack,
    output logic [N_STAGES-1:0] rst_out,
    output logic                all_ready,
    output logic                fault,
    output logic [RC_W-1:0]     retry_cnt
);

    localparam int CNT_MAX = (STAGE_DELAY > TIMEOUT) ? STAGE_DELAY : TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_STAGES - 1);
    localparam logic [RC_W-1:0]  RETRY_LIM = RC_W'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_ACK,
        S_RUN,
        S_FAULT
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [N_STAGES-1:0]   r_rst_out;
    logic [N_STAGES-1:0]   w_rst_nxt;
    logic                  r_all_ready;
    logic                  w_ready_nxt;
    logic                  r_fault;
    logic                  w_fault_nxt;
    logic [RC_W-1:0]       r_retry_cnt;
    logic [RC_W-1:0]       w_retry_nxt;

    logic                  r_lock_p0;
    logic                  r_lock_p1;
    logic [N_STAGES-1:0]   w_idx_oh;
    logic                  w_ack_sel;

    // lock_in synchronizer: p0 may go metastable, p1 is the clean copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_p0 <= 1'b0;
            r_lock_p1 <= 1'b0;
        end else begin
            r_lock_p0 <= lock_in;
            r_lock_p1 <= r_lock_p0;
        end
    end

    always_comb begin
        w_idx_oh = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            w_idx_oh[i] = (r_idx == IDX_W'(i));
        end
    end

    assign w_ack_sel = |(stage_ack & w_idx_oh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_rst_out   <= '1;
            r_all_ready <= 1'b0;
            r_fault     <= 1'b0;
            r_retry_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_rst_out   <= w_rst_nxt;
            r_all_ready <= w_ready_nxt;
            r_fault     <= w_fault_nxt;
            r_retry_cnt <= w_retry_nxt;
        end
    end

    // Acknowledge is tested before the timeout so an ack on the last allowed
    // ACK cycle still advances the sequence instead of retrying.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rst_nxt   = r_rst_out;
        w_ready_nxt = r_all_ready;
        w_fault_nxt = r_fault;
        w_retry_nxt = r_retry_cnt;

        if (sw_rst_req) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_rst_nxt   = '1;
            w_ready_nxt = 1'b0;
            w_fault_nxt = 1'b0;
            w_retry_nxt = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_rst_nxt   = '1;
                    w_ready_nxt = 1'b0;
                    if (r_lock_p1) begin
                        w_state_nxt = S_DELAY;
                    end
                end

                S_DELAY: begin
                    if (!r_lock_p1) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_rst_nxt   = '1;
                        w_ready_nxt = 1'b0;
                    end else if (r_cnt == DLY_LAST) begin
                        w_state_nxt = S_ACK;
                        w_cnt_nxt   = '0;
                        w_rst_nxt   = r_rst_out & ~w_idx_oh;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end

                S_ACK: begin
                    if (!r_lock_p1) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_rst_nxt   = '1;
                        w_ready_nxt = 1'b0;
                    end else if (w_ack_sel) begin
                        w_cnt_nxt = '0;
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = S_RUN;
                            w_ready_nxt = 1'b1;
                            w_retry_nxt = '0;
                        end else begin
                            w_state_nxt = S_DELAY;
                            w_idx_nxt   = r_idx + IDX_W'(1);
                        end
                    end else if (r_cnt == TO_LAST) begin
                        w_cnt_nxt = '0;
                        w_idx_nxt = '0;
                        w_rst_nxt = '1;
                        if (r_retry_cnt < RETRY_LIM) begin
                            w_state_nxt = S_IDLE;
                            w_retry_nxt = r_retry_cnt + RC_W'(1);
                        end else begin
                            w_state_nxt = S_FAULT;
                            w_fault_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end

                S_RUN: begin
                    if (!r_lock_p1) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_rst_nxt   = '1;
                        w_ready_nxt = 1'b0;
                    end
                end

                S_FAULT: begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_rst_nxt   = '1;
                    w_ready_nxt = 1'b0;
                    w_fault_nxt = 1'b1;
                end

                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_rst_nxt   = '1;
                    w_ready_nxt = 1'b0;
                end
            endcase
        end
    end

    assign rst_out   = r_rst_out;
    assign all_ready = r_all_ready;
    assign fault     = r_fault;
    assign retry_cnt = r_retry_cnt;

endmodule
